// File: rtl/tcdm_bank_model_pkg.sv
// Shared types and constants for the TCDM bank model: grant policies and the
// grant LFSR polynomial.
package tcdm_bank_model_pkg;

  typedef enum logic [1:0] {
    GNT_ALWAYS,
    GNT_RANDOM,
    GNT_PERIODIC
  } gnt_mode_e;

  // Fibonacci taps 16,14,13,11 as bit positions 0,2,3,5 of a right-shifting register.
  localparam logic [15:0] LfsrTaps = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LfsrTaps), state[15:1]};
  endfunction

endpackage

// File: rtl/tcdm_bank_model_if.sv
// Multi-bank TCDM request/response bundle; master drives requests, slave
// (the memory model) drives grants and read responses.
interface tcdm_bank_model_if #(
  parameter int unsigned NbBanks   = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 1
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic [NbBanks-1:0]                req_i;
  logic [NbBanks-1:0]                gnt_o;
  logic [NbBanks-1:0]                wen_i;
  logic [NbBanks-1:0][AddrWidth-1:0] add_i;
  logic [NbBanks-1:0][DataWidth-1:0] data_i;
  logic [NbBanks-1:0][BeWidth-1:0]   be_i;
  logic [NbBanks-1:0][IdWidth-1:0]   id_i;
  logic [NbBanks-1:0][DataWidth-1:0] r_data_o;
  logic [NbBanks-1:0]                r_valid_o;
  logic [NbBanks-1:0][IdWidth-1:0]   r_id_o;

  modport master (
    output req_i, wen_i, add_i, data_i, be_i, id_i,
    input  gnt_o, r_data_o, r_valid_o, r_id_o
  );

  modport slave (
    input  req_i, wen_i, add_i, data_i, be_i, id_i,
    output gnt_o, r_data_o, r_valid_o, r_id_o
  );

endinterface

// File: rtl/tcdm_bank_model_bank.sv
// One independent TCDM bank: grant generator, byte-enabled word memory and a
// fixed-latency read response pipeline.
module tcdm_bank_model_bank
  import tcdm_bank_model_pkg::*;
#(
  parameter int unsigned BankSize    = 256,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned Latency     = 1,
  parameter gnt_mode_e   GntMode     = GNT_ALWAYS,
  parameter int unsigned StallPeriod = 4,
  parameter logic [15:0] Seed        = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   wen_i,
  input  logic [AddrWidth-1:0]   add_i,
  input  logic [DataWidth-1:0]   data_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [IdWidth-1:0]     id_i,
  output logic [DataWidth-1:0]   r_data_o,
  output logic                   r_valid_o,
  output logic [IdWidth-1:0]     r_id_o
);
  localparam int unsigned BeWidth  = DataWidth / 8;
  localparam int unsigned IdxWidth = $clog2(BankSize);
  localparam int unsigned CntWidth = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(StallPeriod - 1);

  logic [15:0]         lfsr_q, lfsr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                gnt_raw, acc;

  assign lfsr_d = lfsr_step(lfsr_q);
  assign cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + CntWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
      cnt_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    gnt_raw = 1'b1;
    case (GntMode)
      GNT_RANDOM:   gnt_raw = lfsr_q[0];
      GNT_PERIODIC: gnt_raw = (cnt_q != CntLast);
      default:      gnt_raw = 1'b1;
    endcase
  end

  // Grant is a function of state only; reset just forces it low.
  assign gnt_o = rst_ni & gnt_raw;
  assign acc   = req_i & gnt_o;

  // Words are stored inverted so the zero power-up state reads as all ones.
  logic [DataWidth-1:0] mem_q [BankSize];
  logic [IdxWidth-1:0]  idx;
  logic [DataWidth-1:0] bit_mask;
  logic                 unused_add;

  assign idx        = add_i[IdxWidth+1:2];
  assign unused_add = ^{add_i[AddrWidth-1:IdxWidth+2], add_i[1:0]};

  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < BeWidth; b++) begin
      bit_mask[b*8 +: 8] = {8{be_i[b]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (acc && !wen_i) begin
      mem_q[idx] <= (mem_q[idx] & ~bit_mask) | (~data_i & bit_mask);
    end
  end

  logic [Latency-1:0]   vld_q;
  logic [DataWidth-1:0] dat_q [Latency];
  logic [IdWidth-1:0]   id_q  [Latency];

  // Payload only moves with a valid token, so the last stage holds its value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        dat_q[i] <= '0;
        id_q[i]  <= '0;
      end
    end else begin
      vld_q[0] <= acc & wen_i;
      if (acc && wen_i) begin
        dat_q[0] <= ~mem_q[idx];
        id_q[0]  <= id_i;
      end
      for (int i = 1; i < Latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
          id_q[i]  <= id_q[i-1];
        end
      end
    end
  end

  assign r_valid_o = vld_q[Latency-1];
  assign r_data_o  = dat_q[Latency-1];
  assign r_id_o    = id_q[Latency-1];

endmodule

// File: rtl/tcdm_bank_model.sv
// Behavioural multi-bank TCDM memory with configurable read latency and grant
// stall policy; each bank is an independent tcdm_bank_model_bank.
module tcdm_bank_model
  import tcdm_bank_model_pkg::*;
#(
  parameter int unsigned NbBanks     = 4,
  parameter int unsigned BankSize    = 256,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned Latency     = 1,
  parameter gnt_mode_e   GntMode     = GNT_ALWAYS,
  parameter int unsigned StallPeriod = 4,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  tcdm_bank_model_if.slave   bus_io
);

  for (genvar i = 0; i < NbBanks; i++) begin : g_bank
    localparam logic [15:0] SeedMix  = LfsrSeed ^ 16'(i);
    // An all-zero seed would lock the LFSR.
    localparam logic [15:0] BankSeed = (SeedMix == 16'h0000) ? 16'h0001 : SeedMix;

    tcdm_bank_model_bank #(
      .BankSize    (BankSize),
      .DataWidth   (DataWidth),
      .AddrWidth   (AddrWidth),
      .IdWidth     (IdWidth),
      .Latency     (Latency),
      .GntMode     (GntMode),
      .StallPeriod (StallPeriod),
      .Seed        (BankSeed)
    ) u_bank (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (bus_io.req_i[i]),
      .gnt_o     (bus_io.gnt_o[i]),
      .wen_i     (bus_io.wen_i[i]),
      .add_i     (bus_io.add_i[i]),
      .data_i    (bus_io.data_i[i]),
      .be_i      (bus_io.be_i[i]),
      .id_i      (bus_io.id_i[i]),
      .r_data_o  (bus_io.r_data_o[i]),
      .r_valid_o (bus_io.r_valid_o[i]),
      .r_id_o    (bus_io.r_id_o[i])
    );
  end

endmodule

// File: tb/tb_tcdm_bank_model.sv
// Bench for tcdm_bank_model: four instances (latency 1 and 3 always-grant,
// periodic, random) with a table of bus vectors and a response scoreboard.
module tb_tcdm_bank_model;
  import tcdm_bank_model_pkg::*;

  localparam int NB   = 4;
  localparam int LatB = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcdm_bank_model_if #(.NbBanks(NB)) bus_a ();
  tcdm_bank_model_if #(.NbBanks(NB)) bus_b ();
  tcdm_bank_model_if #(.NbBanks(NB)) bus_p ();
  tcdm_bank_model_if #(.NbBanks(NB)) bus_r ();

  tcdm_bank_model #(.NbBanks(NB), .Latency(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .bus_io(bus_a));
  tcdm_bank_model #(.NbBanks(NB), .Latency(LatB)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .bus_io(bus_b));
  tcdm_bank_model #(.NbBanks(NB), .GntMode(GNT_PERIODIC), .StallPeriod(4)) dut_p (
    .clk_i(clk), .rst_ni(rst_ni), .bus_io(bus_p));
  tcdm_bank_model #(.NbBanks(NB), .GntMode(GNT_RANDOM), .LfsrSeed(16'hACE1)) dut_r (
    .clk_i(clk), .rst_ni(rst_ni), .bus_io(bus_r));

  typedef struct {
    int          bank;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        id;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        id;
    int          cyc;
  } exp_t;

  // Slot d*NB+b: d=0 latency-1 instance, d=1 latency-3 instance.
  exp_t        sb_q [2*NB][$];
  logic [31:0] last_d  [2*NB];
  logic        last_id [2*NB];
  vec_t        vecs[$];
  logic [11:0] rnd0 [2];
  logic [11:0] rnd1 [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int bank, input logic wen, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] be, input logic id,
                              input logic [31:0] exp);
    vec_t v;
    v.bank = bank; v.wen = wen; v.addr = addr; v.data = data;
    v.be = be; v.id = id; v.exp = exp;
    return v;
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(fb) << 15);
  endfunction

  function automatic bit sb_empty();
    for (int i = 0; i < 2 * NB; i++) if (sb_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle_ab();
    bus_a.req_i = '0;
    bus_b.req_i = '0;
  endtask

  // Drive one vector to both always-grant instances for one cycle.
  task automatic apply(input vec_t v);
    idle_ab();
    bus_a.req_i[v.bank] = 1'b1;      bus_b.req_i[v.bank] = 1'b1;
    bus_a.wen_i[v.bank] = v.wen;     bus_b.wen_i[v.bank] = v.wen;
    bus_a.add_i[v.bank] = v.addr;    bus_b.add_i[v.bank] = v.addr;
    bus_a.data_i[v.bank] = v.data;   bus_b.data_i[v.bank] = v.data;
    bus_a.be_i[v.bank] = v.be;       bus_b.be_i[v.bank] = v.be;
    bus_a.id_i[v.bank] = v.id;       bus_b.id_i[v.bank] = v.id;
    if (v.wen) begin
      sb_q[v.bank].push_back('{v.exp, v.id, cyc + 1});
      sb_q[NB + v.bank].push_back('{v.exp, v.id, cyc + LatB});
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < NB; b++) begin
        int          s;
        logic        v;
        logic [31:0] rd;
        logic        ri;
        exp_t        e;
        s  = d * NB + b;
        v  = (d == 0) ? bus_a.r_valid_o[b] : bus_b.r_valid_o[b];
        rd = (d == 0) ? bus_a.r_data_o[b]  : bus_b.r_data_o[b];
        ri = (d == 0) ? bus_a.r_id_o[b]    : bus_b.r_id_o[b];
        if (!rst_ni) begin
          last_d[s]  = '0;
          last_id[s] = 1'b0;
        end
        if (v) begin
          if (sb_q[s].size() == 0) begin
            check($sformatf("unexpected_rvalid d%0d b%0d", d, b), v, 1'b0);
          end else begin
            e = sb_q[s].pop_front();
            check($sformatf("rdata d%0d b%0d", d, b), rd, e.data);
            check($sformatf("rid d%0d b%0d", d, b), ri, e.id);
            check($sformatf("rcycle d%0d b%0d", d, b), cyc, e.cyc);
            last_d[s]  = rd;
            last_id[s] = ri;
          end
        end else begin
          check($sformatf("hold_data d%0d b%0d", d, b), rd, last_d[s]);
          check($sformatf("hold_id d%0d b%0d", d, b), ri, last_id[s]);
        end
      end
    end
  end

  // Release reset at a falling edge and watch the first cycles of the periodic
  // and random grant policies; periodic bank 0 writes every cycle meanwhile.
  task automatic release_and_capture(input int run);
    logic [15:0] m0, m1;
    m0 = 16'hACE1;
    m1 = 16'hACE0;
    @(negedge clk);
    rst_ni = 1'b1;
    bus_p.req_i = 4'b0001;
    bus_p.wen_i[0] = 1'b0;
    bus_p.add_i[0] = 32'h40;
    bus_p.be_i[0] = 4'hF;
    bus_p.data_i[0] = 32'h100;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("per_gnt k%0d", k), bus_p.gnt_o[0], (k % 4) != 3);
      check($sformatf("rnd_gnt0 k%0d", k), bus_r.gnt_o[0], m0[0]);
      check($sformatf("rnd_gnt1 k%0d", k), bus_r.gnt_o[1], m1[0]);
      rnd0[run][k] = bus_r.gnt_o[0];
      rnd1[run][k] = bus_r.gnt_o[1];
      m0 = ref_lfsr(m0);
      m1 = ref_lfsr(m1);
      @(posedge clk); #1;
      if (k == 11) begin
        bus_p.wen_i[0] = 1'b1;
        bus_p.id_i[0] = 1'b1;
      end else begin
        bus_p.data_i[0] = 32'h100 + 32'(k + 1);
      end
      @(negedge clk);
    end
    // Cycles 3, 7 and 11 stall, so the last write landing is cycle 10's.
    @(posedge clk); #1;
    bus_p.req_i = '0;
    @(negedge clk);
    check("per_rvalid", bus_p.r_valid_o[0], 1'b1);
    check("per_rdata", bus_p.r_data_o[0], 32'h10A);
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin end
    bus_a.req_i = '0; bus_a.wen_i = '0; bus_a.add_i = '0; bus_a.data_i = '0;
    bus_a.be_i = '0; bus_a.id_i = '0;
    bus_b.req_i = '0; bus_b.wen_i = '0; bus_b.add_i = '0; bus_b.data_i = '0;
    bus_b.be_i = '0; bus_b.id_i = '0;
    bus_p.req_i = '0; bus_p.wen_i = '0; bus_p.add_i = '0; bus_p.data_i = '0;
    bus_p.be_i = '0; bus_p.id_i = '0;
    bus_r.req_i = '0; bus_r.wen_i = '0; bus_r.add_i = '0; bus_r.data_i = '0;
    bus_r.be_i = '0; bus_r.id_i = '0;

    vecs.push_back(mk(0, 1'b0, 32'h10,  32'hDEADBEEF, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b1, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1'b0, 32'h20,  32'h0000AB00, 4'h2, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b1, 32'h20,  32'h0,        4'h0, 1'b0, 32'hFFFFABFF));
    vecs.push_back(mk(1, 1'b0, 32'h10,  32'h12345678, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(1, 1'b1, 32'h10,  32'h0,        4'h0, 1'b1, 32'h12345678));
    vecs.push_back(mk(0, 1'b1, 32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1'b0, 32'h0,   32'h11111111, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b0, 32'h4,   32'h22222222, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b0, 32'h8,   32'h33333333, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b0, 32'hC,   32'h44444444, 4'hF, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b1, 32'h0,   32'h0,        4'h0, 1'b0, 32'h11111111));
    vecs.push_back(mk(0, 1'b1, 32'h4,   32'h0,        4'h0, 1'b1, 32'h22222222));
    vecs.push_back(mk(0, 1'b1, 32'h8,   32'h0,        4'h0, 1'b0, 32'h33333333));
    vecs.push_back(mk(0, 1'b1, 32'hC,   32'h0,        4'h0, 1'b1, 32'h44444444));
    vecs.push_back(mk(0, 1'b1, 32'h413, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1'b0, 32'h3FC, 32'hA5A5A5A5, 4'h9, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b1, 32'h3FC, 32'h0,        4'h0, 1'b0, 32'hA5FFFFA5));
    vecs.push_back(mk(0, 1'b0, 32'h10,  32'h0,        4'h0, 1'b0, 32'h0));
    vecs.push_back(mk(0, 1'b1, 32'h10,  32'h0,        4'h0, 1'b1, 32'hDEADBEEF));
    vecs.push_back(mk(2, 1'b1, 32'h44,  32'h0,        4'h0, 1'b1, 32'hFFFFFFFF));

    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt_always", bus_a.gnt_o, 4'h0);
    check("rst_gnt_periodic", bus_p.gnt_o, 4'h0);
    check("rst_gnt_random", bus_r.gnt_o, 4'h0);
    release_and_capture(0);

    @(posedge clk); #1;
    foreach (vecs[i]) apply(vecs[i]);
    idle_ab();
    for (int t = 0; t < 20 && !sb_empty(); t++) @(negedge clk);

    // Reset with two reads in flight on the latency-3 instance.
    apply(mk(0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF));
    apply(mk(0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'hFFFFABFF));
    rst_ni = 1'b0;
    idle_ab();
    foreach (sb_q[i]) sb_q[i].delete();
    repeat (2) @(negedge clk);
    release_and_capture(1);
    check("rnd_repeat_bank0", rnd0[1], rnd0[0]);
    check("rnd_repeat_bank1", rnd1[1], rnd1[0]);
    check("rnd_banks_differ", rnd0[0] != rnd1[0], 1'b1);

    @(posedge clk); #1;
    apply(mk(0, 1'b1, 32'h10,  32'h0, 4'h0, 1'b1, 32'hDEADBEEF));
    apply(mk(1, 1'b1, 32'h10,  32'h0, 4'h0, 1'b0, 32'h12345678));
    apply(mk(0, 1'b1, 32'h3FC, 32'h0, 4'h0, 1'b1, 32'hA5FFFFA5));
    idle_ab();
    for (int t = 0; t < 20 && !sb_empty(); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 2 * NB; i++) begin
      check($sformatf("drain slot%0d", i), sb_q[i].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
